// File: rtl/alu_pkg.sv
// Shared opcode map, flag bundle and constants for the round-robin ALU scheduler.
// The divide-by-zero error output is enabled by defining ALU_RR_DIVZERO_EN.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_ROL  = 4'h6;
    localparam logic [3:0] OP_ROR  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;
    localparam logic [3:0] OP_NAND = 4'hC;
    localparam logic [3:0] OP_XNOR = 4'hD;
    localparam logic [3:0] OP_GT   = 4'hE;
    localparam logic [3:0] OP_EQ   = 4'hF;

    localparam logic [7:0] DIV0_RESULT = 8'hFF;

    typedef struct packed {
        logic carry;
        logic zero;
        logic ovf;
    } alu_flags_t;

    // Overflow compares operand signs with the result sign, regardless of opcode.
    function automatic logic ovf_of(input logic a7, input logic b7, input logic r7);
        return (a7 == b7) && (r7 != a7);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational 8-bit ALU: 16 opcodes plus carry/zero/overflow and a div-by-zero flag.
module alu_core
    import alu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] sel,
    output logic [7:0] result,
    output logic       carry,
    output logic       zero,
    output logic       ovf,
    output logic       div0
);

    logic [8:0]  sum9;
    logic [15:0] prod;
    logic [7:0]  quot;

    assign sum9 = {1'b0, a} + {1'b0, b};
    assign prod = {8'h00, a} * {8'h00, b};
    assign div0 = (sel == OP_DIV) && (b == 8'h00);
    // The divider is never allowed to see a zero divisor so the result stays defined.
    assign quot = (b == 8'h00) ? DIV0_RESULT : (a / b);

    always_comb begin
        result = 8'h00;
        case (sel)
            OP_ADD:  result = sum9[7:0];
            OP_SUB:  result = a - b;
            OP_MUL:  result = prod[7:0];
            OP_DIV:  result = quot;
            OP_SHL:  result = {a[6:0], 1'b0};
            OP_SHR:  result = {1'b0, a[7:1]};
            OP_ROL:  result = {a[6:0], a[7]};
            OP_ROR:  result = {a[0], a[7:1]};
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            OP_NAND: result = ~(a & b);
            OP_XNOR: result = ~(a ^ b);
            OP_GT:   result = (a > b)  ? 8'h01 : 8'h00;
            OP_EQ:   result = (a == b) ? 8'h01 : 8'h00;
            default: result = 8'h00;
        endcase
    end

    // Carry is always the add carry, even for non-add opcodes.
    assign carry = sum9[8];
    assign zero  = (result == 8'h00);
    assign ovf   = ovf_of(a[7], b[7], result[7]);

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one ALU among NREQ requesters, with a one-entry output slot.
// Define ALU_RR_DIVZERO_EN to register a divide-by-zero indication on resp_err.
module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    input  logic [NREQ*4-1:0] req_sel,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [7:0]        resp_data,
    output logic              resp_carry,
    output logic              resp_zero,
    output logic              resp_ovf,
    output logic [IDW-1:0]    resp_id,
    output logic              resp_err
);

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] win;
    logic           any_valid;
    logic           slot_free;
    logic           grant;

    logic [7:0]     op_a;
    logic [7:0]     op_b;
    logic [3:0]     op_sel;

    logic [7:0]     core_result;
    logic           core_carry;
    logic           core_zero;
    logic           core_ovf;
    logic           core_div0;

    logic           valid_q;
    logic [7:0]     data_q;
    alu_flags_t     flags_q;
    logic [IDW-1:0] id_q;

    // Scan from rr_ptr upward with wrap; the first requester with valid set wins.
    always_comb begin
        logic [IDW:0] pos;
        any_valid = 1'b0;
        win       = '0;
        pos       = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (pos >= (IDW+1)'(NREQ)) begin
                pos = pos - (IDW+1)'(NREQ);
            end
            if (!any_valid && req_valid[pos[IDW-1:0]]) begin
                any_valid = 1'b1;
                win       = pos[IDW-1:0];
            end
        end
    end

    assign slot_free = !valid_q || resp_ready;
    assign grant     = !rst && slot_free && any_valid;
    assign req_ready = grant ? (NREQ'(1) << win) : '0;

    assign op_a   = req_a[{win, 3'b000} +: 8];
    assign op_b   = req_b[{win, 3'b000} +: 8];
    assign op_sel = req_sel[{win, 2'b00} +: 4];

    alu_core u_alu_core (
        .a      (op_a),
        .b      (op_b),
        .sel    (op_sel),
        .result (core_result),
        .carry  (core_carry),
        .zero   (core_zero),
        .ovf    (core_ovf),
        .div0   (core_div0)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
        end
    end

    // A grant refills the slot even on the cycle it drains, giving one op per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            flags_q <= '0;
            id_q    <= '0;
        end else if (grant) begin
            valid_q       <= 1'b1;
            data_q        <= core_div0 ? DIV0_RESULT : core_result;
            flags_q.carry <= core_carry;
            flags_q.zero  <= core_zero;
            flags_q.ovf   <= core_ovf;
            id_q          <= win;
        end else if (resp_ready) begin
            valid_q <= 1'b0;
        end
    end

`ifdef ALU_RR_DIVZERO_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (grant) begin
            err_q <= core_div0;
        end
    end

    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign resp_valid = valid_q;
    assign resp_data  = data_q;
    assign resp_carry = flags_q.carry;
    assign resp_zero  = flags_q.zero;
    assign resp_ovf   = flags_q.ovf;
    assign resp_id    = id_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench for alu_rr_scheduler: stimulus pushes expected results, a monitor pops and compares.
// Expects resp_err only when ALU_RR_DIVZERO_EN is defined.
module tb_alu_rr_scheduler;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

`ifdef ALU_RR_DIVZERO_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_a;
    logic [NREQ*8-1:0] req_b;
    logic [NREQ*4-1:0] req_sel;
    logic              resp_valid;
    logic              resp_ready;
    logic [7:0]        resp_data;
    logic              resp_carry;
    logic              resp_zero;
    logic              resp_ovf;
    logic [IDW-1:0]    resp_id;
    logic              resp_err;

    typedef struct {
        logic [7:0]     data;
        logic           carry;
        logic           zero;
        logic           ovf;
        logic [IDW-1:0] id;
        logic           err;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [7:0] data;
        logic       carry;
        logic       zero;
        logic       ovf;
    } vec_t;

    exp_t expQueue[$];
    int   checkCount = 0;
    int   passCount  = 0;

    alu_rr_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sel    (req_sel),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_carry (resp_carry),
        .resp_zero  (resp_zero),
        .resp_ovf   (resp_ovf),
        .resp_id    (resp_id),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    task automatic pushExp(input int id, input logic [7:0] data, input logic c, input logic z,
                           input logic o, input logic err);
        exp_t e;
        e.data  = data;
        e.carry = c;
        e.zero  = z;
        e.ovf   = o;
        e.id    = IDW'(id);
        e.err   = err;
        expQueue.push_back(e);
    endtask

    task automatic setReq(input int id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        req_a[id*8 +: 8]   = a;
        req_b[id*8 +: 8]   = b;
        req_sel[id*4 +: 4] = sel;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic rdy);
        @(posedge clk);
        #1;
        req_valid  = valid;
        resp_ready = rdy;
    endtask

    // One lone requester issues one op; its result is popped by the monitor in the next cycle.
    task automatic issueOne(input int id, input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                            input logic [7:0] data, input logic c, input logic z, input logic o,
                            input logic err);
        @(posedge clk);
        #1;
        setReq(id, a, b, sel);
        req_valid  = NREQ'(1) << id;
        resp_ready = 1'b1;
        @(negedge clk);
        checkOutput($sformatf("grant_req%0d_sel%0h", id, sel), 32'(req_ready), 32'(NREQ'(1) << id));
        pushExp(id, data, c, z, o, err);
        applyStimulus('0, 1'b1);
    endtask

    // Monitor: every accepted response is compared against the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && resp_valid && resp_ready) begin
                checkOutput("resp_pending", 32'(expQueue.size() > 0), 32'd1);
                if (expQueue.size() > 0) begin
                    e = expQueue.pop_front();
                    checkOutput("resp_data",  32'(resp_data),  32'(e.data));
                    checkOutput("resp_carry", 32'(resp_carry), 32'(e.carry));
                    checkOutput("resp_zero",  32'(resp_zero),  32'(e.zero));
                    checkOutput("resp_ovf",   32'(resp_ovf),   32'(e.ovf));
                    checkOutput("resp_id",    32'(resp_id),    32'(e.id));
                    checkOutput("resp_err",   32'(resp_err),   32'(e.err));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[11];
        vec_t rrVec[4];

        vecs[0]  = '{8'h81, 8'h01, 4'h4, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{8'h81, 8'h01, 4'h6, 8'h03, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{8'h81, 8'h01, 4'h7, 8'hC0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{8'h81, 8'h01, 4'hC, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{8'h81, 8'h01, 4'hE, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{8'h81, 8'h01, 4'hF, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{8'h03, 8'h05, 4'h1, 8'hFE, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{8'hC8, 8'h40, 4'h9, 8'hC8, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{8'h40, 8'h40, 4'h0, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{8'h0F, 8'hF0, 4'hD, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{8'h64, 8'h07, 4'h3, 8'h0E, 1'b0, 1'b0, 1'b0};

        rrVec[0] = '{8'h10, 8'h05, 4'h1, 8'h0B, 1'b0, 1'b0, 1'b0};
        rrVec[1] = '{8'h20, 8'h03, 4'h2, 8'h60, 1'b0, 1'b0, 1'b0};
        rrVec[2] = '{8'hF0, 8'h0F, 4'hA, 8'hFF, 1'b0, 1'b0, 1'b0};
        rrVec[3] = '{8'h09, 8'h03, 4'h5, 8'h04, 1'b0, 1'b0, 1'b0};

        // Reset with every requester asking: nothing may be granted or presented.
        rst        = 1'b1;
        req_valid  = '1;
        resp_ready = 1'b1;
        req_a      = 32'h11223344;
        req_b      = 32'h55667788;
        req_sel    = 16'h1234;
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_req_ready",  32'(req_ready),  32'd0);
            checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
            checkOutput("rst_resp_data",  32'(resp_data),  32'd0);
            checkOutput("rst_flags",      32'({resp_carry, resp_zero, resp_ovf}), 32'd0);
            checkOutput("rst_resp_id",    32'(resp_id),    32'd0);
            checkOutput("rst_resp_err",   32'(resp_err),   32'd0);
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;

        $display("[TB] single op");
        issueOne(0, 8'h0A, 8'h02, 4'h0, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("single_slot_empty", 32'(resp_valid), 32'd0);

        $display("[TB] round-robin fairness");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            setReq(i, rrVec[i].a, rrVec[i].b, rrVec[i].sel);
        end
        req_valid  = '1;
        resp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
                checkOutput("rr_resp_each_cycle", 32'(resp_valid), 32'd1);
            end
            @(negedge clk);
            checkOutput($sformatf("rr_grant_%0d", k), 32'(req_ready), 32'(NREQ'(1) << (k % 4)));
            pushExp(k % 4, rrVec[k % 4].data, rrVec[k % 4].carry, rrVec[k % 4].zero,
                    rrVec[k % 4].ovf, 1'b0);
        end
        applyStimulus('0, 1'b1);
        @(negedge clk);

        $display("[TB] backpressure");
        @(posedge clk);
        #1;
        setReq(1, 8'h05, 8'h03, 4'h2);
        setReq(2, 8'hFF, 8'h01, 4'h8);
        req_valid  = 4'b0110;
        resp_ready = 1'b0;
        @(negedge clk);
        checkOutput("bp_first_grant", 32'(req_ready), 32'b0010);
        pushExp(1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0100, 1'b0);
            @(negedge clk);
            checkOutput("bp_req_ready", 32'(req_ready),  32'd0);
            checkOutput("bp_valid",     32'(resp_valid), 32'd1);
            checkOutput("bp_data_hold", 32'(resp_data),  32'h0F);
            checkOutput("bp_id_hold",   32'(resp_id),    32'd1);
        end
        applyStimulus(4'b0100, 1'b1);
        @(negedge clk);
        checkOutput("bp_refill_grant", 32'(req_ready), 32'b0100);
        pushExp(2, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus('0, 1'b1);
        @(negedge clk);

        $display("[TB] flags");
        issueOne(3, 8'hF0, 8'h20, 4'h0, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        issueOne(0, 8'h80, 8'h80, 4'h0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);

        $display("[TB] opcode vectors");
        for (int k = 0; k < 11; k++) begin
            issueOne(k % 4, vecs[k].a, vecs[k].b, vecs[k].sel, vecs[k].data,
                     vecs[k].carry, vecs[k].zero, vecs[k].ovf, 1'b0);
        end

        $display("[TB] divide by zero");
        issueOne(1, 8'h11, 8'h00, 4'h3, 8'hFF, 1'b0, 1'b0, 1'b1, ERR_EN);
        @(negedge clk);

        $display("[TB] reset mid-operation");
        @(posedge clk);
        #1;
        setReq(2, 8'h07, 8'h02, 4'h3);
        req_valid  = 4'b0100;
        resp_ready = 1'b0;
        @(negedge clk);
        checkOutput("mid_grant", 32'(req_ready), 32'b0100);
        @(posedge clk);
        #1;
        req_valid = 4'b0100;
        rst       = 1'b1;
        @(negedge clk);
        checkOutput("mid_held_valid", 32'(resp_valid), 32'd1);
        checkOutput("mid_held_data",  32'(resp_data),  32'h03);
        checkOutput("mid_rst_ready",  32'(req_ready),  32'd0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b1;
        @(negedge clk);
        checkOutput("mid_discard_valid", 32'(resp_valid), 32'd0);
        checkOutput("mid_discard_data",  32'(resp_data),  32'd0);

        repeat (2) @(negedge clk);
        checkOutput("queue_drained", 32'(expQueue.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
